// File: rtl/rl_ram_1r1w_fifo_ctrl.sv
// rl_ram_1r1w_fifo_ctrl
// FIFO controller that keeps its storage in an external 1R1W RAM with a
// registered (1-cycle) read port. The controller owns the pointers, the
// occupancy bookkeeping and the consumer-side valid flag; the RAM holds data.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. The producer may hold wr_valid_i/wr_data_i until
// wr_ready_o is seen; the controller holds rd_valid_o/rd_data_o stable until
// rd_ready_i is seen. wr_ready_o depends only on registered state.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   clr_i                   synchronous flush, overrides push/pop
//   wr_valid_i, wr_data_i   producer side, wr_ready_o = space available
//   rd_valid_o, rd_data_o   consumer side, rd_ready_i = head accepted
//   count_o                 occupancy 0 .. 2**ABITS
//   empty_o, almost_full_o  occupancy flags
//   ram_*                   external RAM write port, read address and data
module rl_ram_1r1w_fifo_ctrl #(
    parameter int ABITS     = 4,
    parameter int DBITS     = 32,
    parameter int AFULL_LVL = 2**ABITS - 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     wr_valid_i,
    input  logic [DBITS-1:0]         wr_data_i,
    output logic                     wr_ready_o,
    output logic                     rd_valid_o,
    output logic [DBITS-1:0]         rd_data_o,
    input  logic                     rd_ready_i,
    output logic [ABITS:0]           count_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic [ABITS-1:0]         ram_waddr_o,
    output logic [DBITS-1:0]         ram_din_o,
    output logic                     ram_we_o,
    output logic [(DBITS+7)/8-1:0]   ram_be_o,
    output logic [ABITS-1:0]         ram_raddr_o,
    input  logic [DBITS-1:0]         ram_dout_i
);

    localparam logic [ABITS:0] DEPTH     = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS:0] AFULL_CNT = (ABITS+1)'(AFULL_LVL);

    logic [ABITS:0] wr_ptr;
    logic [ABITS:0] rd_ptr;
    logic [ABITS:0] rd_ptr_nxt;
    logic           rd_valid_q;
    logic           push;
    logic           pop;

    // The extra MSB on each pointer distinguishes full from empty when the
    // RAM address bits are equal; the subtraction wraps naturally.
    assign count_o       = wr_ptr - rd_ptr;
    assign empty_o       = (count_o == '0);
    assign almost_full_o = (count_o >= AFULL_CNT);
    assign wr_ready_o    = (count_o != DEPTH);

    // rst_ni is folded in so the RAM never sees a write while reset is held.
    assign push = wr_valid_i & wr_ready_o & ~clr_i & rst_ni;
    assign pop  = rd_valid_q & rd_ready_i;

    // The read address runs one step ahead of the registered head so the RAM
    // output register already holds the next entry when a pop is taken.
    assign rd_ptr_nxt  = rd_ptr + {{ABITS{1'b0}}, pop};
    assign ram_raddr_o = rd_ptr_nxt[ABITS-1:0];

    assign ram_we_o    = push;
    assign ram_waddr_o = wr_ptr[ABITS-1:0];
    assign ram_din_o   = wr_data_i;
    assign ram_be_o    = '1;

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = ram_dout_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
        end else if (clr_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + {{ABITS{1'b0}}, push};
            rd_ptr     <= rd_ptr_nxt;
            // Compare against the pre-edge write pointer: an entry written at
            // this same edge cannot be read yet (read-old-data collision), so
            // it only becomes visible one edge later.
            rd_valid_q <= (rd_ptr_nxt != wr_ptr);
        end
    end

endmodule

// File: tb/tb_rl_ram_1r1w_fifo_ctrl.sv
// Bench for rl_ram_1r1w_fifo_ctrl (ABITS=2, DBITS=8, AFULL_LVL=3) with a
// behavioural RAM and a queue model of the FIFO contents.
module tb_rl_ram_1r1w_fifo_ctrl;

    localparam int ABITS = 2;
    localparam int DBITS = 8;
    localparam int AFULL = 3;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             wr_valid;
    logic [DBITS-1:0] wr_data;
    logic             wr_ready;
    logic             rd_valid;
    logic [DBITS-1:0] rd_data;
    logic             rd_ready;
    logic [ABITS:0]   count;
    logic             empty;
    logic             almost_full;
    logic [ABITS-1:0] ram_waddr;
    logic [DBITS-1:0] ram_din;
    logic             ram_we;
    logic [0:0]       ram_be;
    logic [ABITS-1:0] ram_raddr;
    logic [DBITS-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    rl_ram_1r1w_fifo_ctrl #(
        .ABITS(ABITS), .DBITS(DBITS), .AFULL_LVL(AFULL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ready_i(rd_ready),
        .count_o(count), .empty_o(empty), .almost_full_o(almost_full),
        .ram_waddr_o(ram_waddr), .ram_din_o(ram_din), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_raddr_o(ram_raddr), .ram_dout_i(ram_dout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM: registered read, read-old-data ----------------
    logic [DBITS-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Contents as a queue; each entry remembers the cycle it was pushed.
    // The head is presented once it was pushed two or more cycles ago.
    logic [DBITS-1:0] q_data [$];
    int               q_stamp[$];
    int               cyc    = 0;
    int               wr_cnt = 0;
    int               rd_cnt = 0;

    function automatic logic model_rd_valid();
        if (q_data.size() == 0) return 1'b0;
        return (q_stamp[0] <= cyc - 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic m_push;
        logic m_pop;
        if (!rst_n) begin
            q_data.delete();
            q_stamp.delete();
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            m_push = wr_valid && (q_data.size() != DEPTH) && !clr;
            m_pop  = model_rd_valid() && rd_ready && !clr;
            if (clr) begin
                q_data.delete();
                q_stamp.delete();
                wr_cnt = 0;
                rd_cnt = 0;
            end else begin
                if (m_pop) begin
                    void'(q_data.pop_front());
                    void'(q_stamp.pop_front());
                    rd_cnt++;
                end
                if (m_push) begin
                    q_data.push_back(wr_data);
                    q_stamp.push_back(cyc);
                    wr_cnt++;
                end
            end
            cyc++;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        int   sz;
        logic erv;
        logic epush;
        logic epop;
        sz    = q_data.size();
        erv   = model_rd_valid();
        epush = rst_n && wr_valid && (sz != DEPTH) && !clr;
        epop  = erv && rd_ready;
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= AFULL));
        chk("wr_ready", 32'(wr_ready), 32'(sz != DEPTH));
        chk("rd_valid", 32'(rd_valid), 32'(erv));
        chk("ram_we", 32'(ram_we), 32'(epush));
        chk("ram_be", 32'(ram_be), 32'd1);
        if (epush) begin
            chk("ram_waddr", 32'(ram_waddr), 32'(wr_cnt % DEPTH));
            chk("ram_din", 32'(ram_din), 32'(wr_data));
        end
        if (erv) chk("rd_data", 32'(rd_data), 32'(q_data[0]));
        if (rst_n && !clr) chk("ram_raddr", 32'(ram_raddr), 32'((rd_cnt + int'(epop)) % DEPTH));
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // single push, visible two cycles later, then popped
        wr_valid = 1'b1; wr_data = 8'hA5;
        mid(); chk("c1_we", 32'(ram_we), 32'd1);
        next_cycle();
        wr_valid = 1'b0;
        mid(); chk("c2_rd_valid", 32'(rd_valid), 32'd0);
        next_cycle();
        rd_ready = 1'b1;
        mid(); chk("c3_rd_valid", 32'(rd_valid), 32'd1);
        chk("c3_rd_data", 32'(rd_data), 32'hA5);
        next_cycle();
        rd_ready = 1'b0;
        mid(); chk("c4_empty", 32'(empty), 32'd1);
        chk("c4_rd_valid", 32'(rd_valid), 32'd0);
        next_cycle();

        // fill to full, fifth push refused
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i + 1);
            mid();
            if (i == 3) begin
                chk("fill3_count", 32'(count), 32'd3);
                chk("fill3_afull", 32'(almost_full), 32'd1);
            end
            next_cycle();
        end
        wr_data = 8'h55;
        mid(); chk("full_count", 32'(count), 32'd4);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_we", 32'(ram_we), 32'd0);
        next_cycle();

        // drain from full, one per cycle
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(i + 1));
            next_cycle();
        end
        mid(); chk("drained_valid", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;
        next_cycle();

        // steady push+pop at count 2 across pointer wraps
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
            next_cycle();
        end
        wr_valid = 1'b0;
        repeat (2) next_cycle();
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'(8'h20 + i);
            mid();
            chk("stream_count", 32'(count), 32'd2);
            chk("stream_data", 32'(rd_data), (i < 2) ? 32'(8'h10 + i) : 32'(8'h20 + i - 2));
            next_cycle();
        end
        wr_valid = 1'b0;
        repeat (4) next_cycle();
        rd_ready = 1'b0;
        next_cycle();

        // flush at count 3 with a concurrent push
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h40 + i);
            next_cycle();
        end
        clr = 1'b1; wr_data = 8'h99;
        mid(); chk("clr_we", 32'(ram_we), 32'd0);
        next_cycle();
        clr = 1'b0; wr_valid = 1'b0;
        mid(); chk("clr_count", 32'(count), 32'd0);
        chk("clr_rd_valid", 32'(rd_valid), 32'd0);
        next_cycle();

        // asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h60 + i);
            next_cycle();
        end
        wr_data = 8'h70;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_afull", 32'(almost_full), 32'd0);
        chk("arst_we", 32'(ram_we), 32'd0);
        repeat (2) next_cycle();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // first push after reset behaves like the first one
        wr_valid = 1'b1; wr_data = 8'h77;
        next_cycle();
        wr_valid = 1'b0;
        mid(); chk("post_rst_c2_valid", 32'(rd_valid), 32'd0);
        next_cycle();
        rd_ready = 1'b1;
        mid(); chk("post_rst_c3_valid", 32'(rd_valid), 32'd1);
        chk("post_rst_c3_data", 32'(rd_data), 32'h77);
        next_cycle();
        rd_ready = 1'b0;
        mid(); chk("post_rst_empty", 32'(empty), 32'd1);
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
